// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and mux selects, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int OPCODE_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BREX   = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'('h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'('h23);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'('h2B);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything stays at its zero default while reset is asserted, so strobes
    // drop in the same cycle reset rises rather than at the next edge.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    if (opcode == OP_RTYPE)                        state_d = S_RTEX;
                    else if (opcode == OP_LW || opcode == OP_SW)   state_d = S_MEMADR;
                    else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BREX;
                    else if (opcode == OP_ADDI)                    state_d = S_ADDIEX;
                    else if (opcode == OP_J)                       state_d = S_JEX;
                    else                                           state_d = S_HALT;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_RTEX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_RTWB;
                end
                S_RTWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BREX: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_source = 2'b01;
                    pc_en     = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JEX: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_HALT: illegal = 1'b1;
                default: state_d = S_HALT;
            endcase
        end
    end

    assign cnt_d         = cnt_q + CNT_W'(retire);
    assign state         = state_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: vector table, directed corner sequences and
// random instruction streams checked against an instruction-level model.
module tb_mips_multicycle_ctrl;
    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       opcode = '0;
    logic             alu_zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic             mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_retired;
    logic [19:0]      act;

    mips_multicycle_ctrl #(.CNT_W(CNT_W), .OPCODE_W(6)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal), .state(state), .instr_retired(instr_retired)
    );

    assign act = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

    // clock / reset
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int model_cnt = 0;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       az;
        logic       ret;
    } stim_t;
    stim_t       stim_q[$];
    logic [19:0] exp_q[$];

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        az;
        logic [19:0] exp;
        int          cnt;
    } vec_t;
    vec_t vt[12];

    // expected output rows, one per datapath step of the instruction set
    function automatic logic [19:0] row(input logic [3:0] st, input logic pe, io, mr, mw, irw,
                                        rd, m2r, rw, asa, input logic [1:0] asb, aop, psrc,
                                        input logic ill);
        return {st, pe, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
    endfunction
    function automatic logic [19:0] f_fetch(input logic done);
        return row(4'd0, done, 0, 1, 0, done, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_decode();
        return row(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_memadr();
        return row(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_memrd();
        return row(4'd3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_memwb();
        return row(4'd4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_memwr();
        return row(4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_rtex();
        return row(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_rtwb();
        return row(4'd7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_brex(input logic take);
        return row(4'd8, take, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    endfunction
    function automatic logic [19:0] f_addiex();
        return row(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_addiwb();
        return row(4'd10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [19:0] f_jex();
        return row(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
    endfunction
    function automatic logic [19:0] f_halt();
        return row(4'd12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // scoreboard checks
    task automatic check_out(input string name, input logic [19:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: outputs got %h want %h at t=%0t", name, act, exp, $time);
    endtask
    task automatic check_cnt(input string name, input int exp);
        n_chk++;
        if (instr_retired === CNT_W'(exp)) n_pass++;
        else $display("FAIL %s: instr_retired got %0d want %0d at t=%0t", name, instr_retired, exp, $time);
    endtask

    // driver tasks; each cycle starts 1 time unit after a rising edge
    task automatic drive(input logic [5:0] op, input logic mr, input logic az);
        opcode    = op;
        mem_ready = mr;
        alu_zero  = az;
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset(input string name);
        reset = 1'b1;
        #3;
        check_out({name, "_during"}, 20'h0);
        check_cnt({name, "_during"}, 0);
        tick();
        reset     = 1'b0;
        model_cnt = 0;
        drive(rop(), 1'b0, rb());
        #3;
        check_out({name, "_after"}, f_fetch(1'b0));
        tick();
    endtask

    task automatic push(input logic [5:0] op, input logic mr, input logic az, input logic ret,
                        input logic [19:0] exp);
        stim_q.push_back('{op: op, mr: mr, az: az, ret: ret});
        exp_q.push_back(exp);
    endtask

    // Instruction-level model: the cycle-by-cycle expectation of one whole
    // instruction, with fw fetch wait cycles and mw memory wait cycles.
    task automatic plan_instr(input logic [5:0] op, input logic az, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(rop(), 1'b0, rb(), 1'b0, f_fetch(1'b0));
        push(rop(), 1'b1, rb(), 1'b0, f_fetch(1'b1));
        push(op, rb(), rb(), 1'b0, f_decode());
        case (op)
            6'h00: begin
                push(op, rb(), rb(), 1'b0, f_rtex());
                push(op, rb(), rb(), 1'b1, f_rtwb());
            end
            6'h23: begin
                push(op, rb(), rb(), 1'b0, f_memadr());
                for (int i = 0; i < mw; i++) push(op, 1'b0, rb(), 1'b0, f_memrd());
                push(op, 1'b1, rb(), 1'b0, f_memrd());
                push(op, rb(), rb(), 1'b1, f_memwb());
            end
            6'h2B: begin
                push(op, rb(), rb(), 1'b0, f_memadr());
                for (int i = 0; i < mw; i++) push(op, 1'b0, rb(), 1'b0, f_memwr());
                push(op, 1'b1, rb(), 1'b1, f_memwr());
            end
            6'h04: push(op, rb(), az, 1'b1, f_brex(az));
            6'h05: push(op, rb(), az, 1'b1, f_brex(~az));
            6'h08: begin
                push(op, rb(), rb(), 1'b0, f_addiex());
                push(op, rb(), rb(), 1'b1, f_addiwb());
            end
            default: push(op, rb(), rb(), 1'b1, f_jex());
        endcase
    endtask

    task automatic run_plan(input string name);
        stim_t       s;
        logic [19:0] e;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            drive(s.op, s.mr, s.az);
            #3;
            check_out(name, e);
            check_cnt(name, model_cnt);
            tick();
            if (s.ret) model_cnt++;
        end
    endtask

    logic [5:0] legal_ops[7];

    initial begin
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
        // addi, then j and an R-type back to back
        vt[0]  = '{op: 6'h08, mr: 1'b1, az: 1'b0, exp: f_fetch(1'b1), cnt: 0};
        vt[1]  = '{op: 6'h08, mr: 1'b1, az: 1'b0, exp: f_decode(),     cnt: 0};
        vt[2]  = '{op: 6'h08, mr: 1'b1, az: 1'b1, exp: f_addiex(),     cnt: 0};
        vt[3]  = '{op: 6'h08, mr: 1'b0, az: 1'b0, exp: f_addiwb(),     cnt: 0};
        vt[4]  = '{op: 6'h02, mr: 1'b1, az: 1'b0, exp: f_fetch(1'b1), cnt: 1};
        vt[5]  = '{op: 6'h02, mr: 1'b0, az: 1'b0, exp: f_decode(),     cnt: 1};
        vt[6]  = '{op: 6'h02, mr: 1'b0, az: 1'b1, exp: f_jex(),        cnt: 1};
        vt[7]  = '{op: 6'h00, mr: 1'b1, az: 1'b0, exp: f_fetch(1'b1), cnt: 2};
        vt[8]  = '{op: 6'h00, mr: 1'b0, az: 1'b0, exp: f_decode(),     cnt: 2};
        vt[9]  = '{op: 6'h00, mr: 1'b1, az: 1'b0, exp: f_rtex(),       cnt: 2};
        vt[10] = '{op: 6'h00, mr: 1'b1, az: 1'b1, exp: f_rtwb(),       cnt: 2};
        vt[11] = '{op: 6'h00, mr: 1'b0, az: 1'b0, exp: f_fetch(1'b0), cnt: 3};

        #1;
        do_reset("reset0");

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].op, vt[i].mr, vt[i].az);
            #3;
            check_out($sformatf("vec%0d", i), vt[i].exp);
            check_cnt($sformatf("vec%0d", i), vt[i].cnt);
            tick();
        end
        model_cnt = 3;

        // lw with three memory wait cycles, then beq/bne both with alu_zero=1
        plan_instr(6'h23, 1'b0, 0, 3);
        run_plan("lw_wait");
        plan_instr(6'h04, 1'b1, 0, 0);
        plan_instr(6'h05, 1'b1, 1, 0);
        run_plan("branch");

        // sw stalled in MEMWR, then reset raised mid-cycle
        drive(6'h2B, 1'b1, 1'b0); #3; check_out("sw_fetch", f_fetch(1'b1)); tick();
        drive(6'h2B, 1'b1, 1'b0); #3; check_out("sw_decode", f_decode()); tick();
        drive(6'h2B, 1'b1, 1'b0); #3; check_out("sw_memadr", f_memadr()); tick();
        drive(6'h2B, 1'b0, 1'b0); #3; check_out("sw_memwr0", f_memwr()); tick();
        drive(6'h2B, 1'b0, 1'b0); #3; check_out("sw_memwr1", f_memwr());
        check_cnt("sw_pre_reset", model_cnt);
        reset = 1'b1;
        #1;
        check_out("sw_reset_drop", 20'h0);
        check_cnt("sw_reset_cnt", 0);
        tick();
        reset     = 1'b0;
        model_cnt = 0;

        // retire two, then an illegal opcode parks the FSM in HALT
        plan_instr(6'h08, 1'b0, 0, 0);
        plan_instr(6'h02, 1'b0, 2, 0);
        run_plan("pre_halt");
        drive(6'h3F, 1'b1, 1'b0); #3; check_out("halt_fetch", f_fetch(1'b1)); tick();
        drive(6'h3F, 1'b1, 1'b0); #3; check_out("halt_decode", f_decode()); tick();
        for (int i = 0; i < 10; i++) begin
            drive(6'h3F, rb(), rb());
            #3;
            check_out("halt_hold", f_halt());
            check_cnt("halt_cnt", model_cnt);
            tick();
        end
        do_reset("halt_reset");

        // random instruction stream
        for (int n = 0; n < 60; n++) begin
            plan_instr(legal_ops[$urandom_range(0, 6)], rb(), $urandom_range(0, 2),
                       $urandom_range(0, 3));
            run_plan("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
